// File: rtl/output_fm_buffer.sv
// Output feature-map tile buffer for the innermost MAC loop.
// Each entry is handed to the MAC as its initial value. The MAC result is
// written back into the same entry, and this repeats for every input-channel
// tile. The finished tile is then streamed out over a valid/ready port.
// Data is treated as opaque bit patterns; no arithmetic is done on it.
//
// state | meaning
// IDLE  | waiting for start_i; bias_i is captured when start_i is seen
// ACCUM | one entry per accepted MAC result, looping over entries and passes
// DRAIN | stream entries 0..DEPTH-1 downstream, last beat flagged
`timescale 1ns/1ps

module output_fm_buffer #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int N_TILES = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic [DATA_W-1:0]          bias_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(DEPTH)-1:0]   addr_o,
    output logic [$clog2(N_TILES):0]   pass_o,
    output logic [DATA_W-1:0]          fm_init_o,
    input  logic                       acc_v_i,
    input  logic [DATA_W-1:0]          fm_i,
    output logic                       out_v_o,
    output logic [DATA_W-1:0]          out_data_o,
    output logic                       out_last_o,
    input  logic                       out_ready_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(N_TILES) + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(N_TILES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [PW-1:0]       pass_q, pass_d;
    logic [DATA_W-1:0]   bias_q, bias_d;
    logic                done_q, done_d;

    // Tile storage; never read before it has been written in pass 0.
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // State register: all control state, asynchronously cleared.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            pass_q  <= '0;
            bias_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pass_q  <= pass_d;
            bias_q  <= bias_d;
            done_q  <= done_d;
        end
    end

    // Write MAC results back into the entry currently being accumulated.
    always_ff @(posedge clk_i) begin
        if (state_q == S_ACCUM && acc_v_i) begin
            mem_q[addr_q] <= fm_i;
        end
    end

    // Next-state logic: entry/pass sequencing and drain handshake.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        bias_d  = bias_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    bias_d  = bias_i;
                    addr_d  = '0;
                    pass_d  = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (acc_v_i) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
                        // pass_o reads N_TILES while draining: all tiles folded in.
                        pass_d = pass_q + 1'b1;
                        if (pass_q == LAST_PASS) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready_i) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: decoded from registered state only, so fm_init_o has no path
    // from acc_v_i or fm_i (fm_i is combinationally derived from fm_init_o).
    always_comb begin
        busy_o     = 1'b0;
        fm_init_o  = '0;
        out_v_o    = 1'b0;
        out_data_o = '0;
        out_last_o = 1'b0;
        unique case (state_q)
            S_ACCUM: begin
                busy_o    = 1'b1;
                fm_init_o = (pass_q == '0) ? bias_q : mem_q[addr_q];
            end
            S_DRAIN: begin
                busy_o     = 1'b1;
                out_v_o    = 1'b1;
                out_data_o = mem_q[addr_q];
                out_last_o = (addr_q == LAST_ADDR);
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    assign done_o = done_q;
    assign addr_o = addr_q;
    assign pass_o = pass_q;

endmodule

// File: tb/tb_output_fm_buffer.sv
// Bench for output_fm_buffer: a DEPTH=4/N_TILES=2 instance and a
// DEPTH=4/N_TILES=1 instance, each closed around a small MAC stand-in.
`timescale 1ns/1ps

module tb_output_fm_buffer;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Instance A: two input-channel tiles, MAC adds 2.0
    logic        a_start, a_busy, a_done, a_acc_v, a_out_v, a_out_last, a_ready;
    logic [31:0] a_bias, a_fm_init, a_fm, a_out_data;
    logic [1:0]  a_addr;
    logic [1:0]  a_pass;

    // Instance B: single tile, MAC adds 0.25
    logic        b_start, b_busy, b_done, b_acc_v, b_out_v, b_out_last, b_ready;
    logic [31:0] b_bias, b_fm_init, b_fm, b_out_data;
    logic [1:0]  b_addr;
    logic [0:0]  b_pass;

    function automatic logic [31:0] mac_a(input logic [31:0] x);
        case (x)
            32'h3F800000: mac_a = 32'h40400000; // 1.0 + 2.0 = 3.0
            32'h40400000: mac_a = 32'h40A00000; // 3.0 + 2.0 = 5.0
            default:      mac_a = 32'h7FC00000;
        endcase
    endfunction

    function automatic logic [31:0] mac_b(input logic [31:0] x);
        case (x)
            32'h3F000000: mac_b = 32'h3F400000; // 0.5 + 0.25 = 0.75
            default:      mac_b = 32'h7FC00000;
        endcase
    endfunction

    assign a_fm = mac_a(a_fm_init);
    assign b_fm = mac_b(b_fm_init);

    output_fm_buffer #(.DATA_W(32), .DEPTH(DEPTH), .N_TILES(2)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(a_start), .bias_i(a_bias),
        .busy_o(a_busy), .done_o(a_done), .addr_o(a_addr), .pass_o(a_pass),
        .fm_init_o(a_fm_init), .acc_v_i(a_acc_v), .fm_i(a_fm),
        .out_v_o(a_out_v), .out_data_o(a_out_data), .out_last_o(a_out_last),
        .out_ready_i(a_ready)
    );

    output_fm_buffer #(.DATA_W(32), .DEPTH(DEPTH), .N_TILES(1)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(b_start), .bias_i(b_bias),
        .busy_o(b_busy), .done_o(b_done), .addr_o(b_addr), .pass_o(b_pass),
        .fm_init_o(b_fm_init), .acc_v_i(b_acc_v), .fm_i(b_fm),
        .out_v_o(b_out_v), .out_data_o(b_out_data), .out_last_o(b_out_last),
        .out_ready_i(b_ready)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_start_tile(input logic [31:0] b);
        a_bias  = b;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        a_bias  = 32'hDEADBEEF;   // bias must have been latched on start
        chk("a_busy_after_start", a_busy, 1);
        chk("a_addr_after_start", a_addr, 0);
        chk("a_pass_after_start", a_pass, 0);
    endtask

    // Accumulate all DEPTH*2 entries; optional 1,0,1,0 stall and stray start.
    task automatic a_accum(input bit stall, input bit poke);
        int acc = 0;
        int cyc = 0;
        int ea = 0;
        int ep = 0;
        logic [31:0] ei;
        while (acc < DEPTH * 2 && cyc < 64) begin
            a_acc_v = stall ? (cyc % 2 == 0) : 1'b1;
            a_start = poke && (cyc == 3);
            ei = (ep == 0) ? 32'h3F800000 : 32'h40400000;
            chk("a_accum_addr", a_addr, ea);
            chk("a_accum_pass", a_pass, ep);
            chk("a_fm_init", a_fm_init, ei);
            chk("a_accum_busy", a_busy, 1);
            chk("a_accum_out_v", a_out_v, 0);
            step();
            if (a_acc_v) begin
                acc++;
                if (ea == DEPTH - 1) begin
                    ea = 0;
                    ep++;
                end else begin
                    ea++;
                end
            end
            cyc++;
        end
        a_acc_v = 1'b0;
        a_start = 1'b0;
        chk("a_accum_count", acc, DEPTH * 2);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(32'h40A00000);
    endtask

    // Drain DEPTH beats; optional ready pattern 0,0,1,0,1,1,1 and stray start.
    task automatic a_drain(input bit bp, input bit poke);
        int beats = 0;
        int cyc = 0;
        bit held = 1'b0;
        logic [31:0] prev = '0;
        logic [31:0] pat = 32'h0000_0074;
        while (beats < DEPTH && cyc < 64) begin
            a_ready = bp ? ((cyc < 7) ? pat[cyc] : 1'b1) : 1'b1;
            a_start = poke && (cyc == 1);
            chk("a_out_v", a_out_v, 1);
            chk("a_drain_addr", a_addr, beats);
            chk("a_out_last", a_out_last, (beats == DEPTH - 1));
            chk("a_drain_fm_init", a_fm_init, 0);
            chk("a_drain_done", a_done, 0);
            if (held) chk("a_data_stable", a_out_data, prev);
            if (a_ready) begin
                chk("a_out_data", a_out_data, exp_q.pop_front());
                beats++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                prev = a_out_data;
            end
            step();
            cyc++;
        end
        a_ready = 1'b0;
        a_start = 1'b0;
        chk("a_drain_count", beats, DEPTH);
        chk("a_done_pulse", a_done, 1);
        chk("a_idle_busy", a_busy, 0);
        chk("a_idle_out_v", a_out_v, 0);
        chk("a_idle_fm_init", a_fm_init, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bit saw_done;
        a_start = 0; a_bias = '0; a_acc_v = 0; a_ready = 0;
        b_start = 0; b_bias = '0; b_acc_v = 0; b_ready = 0;
        rst_n = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_out_v", a_out_v, 0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_fm_init", a_fm_init, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_pass", a_pass, 0);
        rst_n = 1'b1;
        step();

        // Basic accumulation and minimum tile time (start..done = 14 cycles,
        // i.e. done is seen 13 edges after the start edge's input setup)
        t0 = cyc_cnt;
        a_start_tile(32'h3F800000);
        a_accum(1'b0, 1'b0);
        a_drain(1'b0, 1'b0);
        chk("a_tile_cycles", cyc_cnt - t0, DEPTH * 2 + DEPTH + 1);
        step();
        chk("a_done_one_cycle", a_done, 0);

        // Stall on acc_v, stray starts during ACCUM and DRAIN
        a_start_tile(32'h3F800000);
        a_accum(1'b1, 1'b1);
        a_drain(1'b0, 1'b1);
        step();
        chk("a_done_one_cycle_stall", a_done, 0);

        // Backpressure, then a start issued in the done cycle
        a_start_tile(32'h3F800000);
        a_accum(1'b0, 1'b0);
        a_drain(1'b1, 1'b0);
        a_start_tile(32'h3F800000);
        a_accum(1'b0, 1'b0);
        a_drain(1'b0, 1'b0);
        step();

        // Reset mid-ACCUM abandons the tile
        a_start_tile(32'h3F800000);
        a_acc_v = 1'b1;
        step();
        step();
        step();
        a_acc_v = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", a_busy, 0);
        chk("midrst_out_v", a_out_v, 0);
        chk("midrst_fm_init", a_fm_init, 0);
        chk("midrst_done", a_done, 0);
        step();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (a_done) saw_done = 1'b1;
        end
        chk("midrst_no_done", saw_done, 0);
        chk("midrst_addr", a_addr, 0);
        chk("midrst_pass", a_pass, 0);
        a_start_tile(32'h3F800000);
        a_accum(1'b0, 1'b0);
        a_drain(1'b0, 1'b0);
        step();

        // Single input-channel tile: bias 0.5, MAC adds 0.25
        b_bias  = 32'h3F000000;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        b_bias  = 32'hDEADBEEF;
        chk("b_busy_after_start", b_busy, 1);
        for (int i = 0; i < DEPTH; i++) begin
            b_acc_v = 1'b1;
            chk("b_fm_init", b_fm_init, 32'h3F000000);
            chk("b_accum_addr", b_addr, i);
            chk("b_accum_pass", b_pass, 0);
            exp_q.push_back(32'h3F400000);
            step();
        end
        b_acc_v = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            b_ready = 1'b1;
            chk("b_out_v", b_out_v, 1);
            chk("b_out_last", b_out_last, (i == DEPTH - 1));
            chk("b_out_data", b_out_data, exp_q.pop_front());
            step();
        end
        b_ready = 1'b0;
        chk("b_done_pulse", b_done, 1);
        chk("b_idle_busy", b_busy, 0);
        step();
        chk("b_done_one_cycle", b_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
